// File: rtl/pwm_transmitter.sv
// -----------------------------------------------------------------------------
// pwm_transmitter
//
// Servo/ESC-style PWM generator on a 1 us time base. An 8-bit command value
// maps onto a MIN_PULSE_US..MAX_PULSE_US high time inside a PERIOD_US frame.
// Commands are double-buffered: value_valid loads a pending register, and the
// pending value is copied into the active length only at a frame boundary, so
// a pulse is never shortened or stretched once it has started.
//
// Frame boundary: the clock edge that opens a frame (counter = 0). Inputs
// sampled at that edge (value_valid/value_in, arm) decide the new frame's
// length, and pwm_out, frame_start and pulse_len_us all reflect the new frame
// in the very cycle the edge opens.
//
// Optional feature, compile-time macro PWM_FAILSAFE_EN:
//   defined   - watchdog counts frames without value_valid; after
//               FAILSAFE_FRAMES of them, failsafe=1 and pulses fall to MIN.
//   undefined - no watchdog; failsafe tied 0; the last value holds forever.
//
// Ports:
//   us_clk        in   1  1 MHz tick clock, all logic on its rising edge
//   resetn        in   1  synchronous active-low reset
//   value_in      in   8  command value
//   value_valid   in   1  single-cycle strobe, loads value_in into pending
//   arm           in   1  0 forces MIN_PULSE_US pulses, 1 uses the command
//   pwm_out       out  1  registered PWM output
//   frame_start   out  1  one-cycle pulse on the first cycle of each frame
//   pulse_len_us  out 12  high time in effect for the current frame
//   failsafe      out  1  watchdog tripped (0 without PWM_FAILSAFE_EN)
// -----------------------------------------------------------------------------
module pwm_transmitter #(
    parameter int unsigned PERIOD_US       = 20000,
    parameter int unsigned MIN_PULSE_US    = 1000,
    parameter int unsigned MAX_PULSE_US    = 2000,
    parameter int unsigned FAILSAFE_FRAMES = 10
) (
    input  logic        us_clk,
    input  logic        resetn,
    input  logic [7:0]  value_in,
    input  logic        value_valid,
    input  logic        arm,
    output logic        pwm_out,
    output logic        frame_start,
    output logic [11:0] pulse_len_us,
    output logic        failsafe
);

    // The 18-bit product holds 8-bit value times a 10-bit span.
    if (MIN_PULSE_US == 0 || MAX_PULSE_US <= MIN_PULSE_US || MAX_PULSE_US > 4095 ||
        (MAX_PULSE_US - MIN_PULSE_US) > 1023 || PERIOD_US < 2 * MAX_PULSE_US ||
        PERIOD_US > 32767 || FAILSAFE_FRAMES == 0) begin : g_param_check
        $error("pwm_transmitter: parameter set out of range");
    end

    localparam logic [14:0] PERIOD_LAST = 15'(PERIOD_US - 1);
    localparam logic [11:0] MIN_LEN     = 12'(MIN_PULSE_US);
    localparam logic [11:0] MAX_LEN     = 12'(MAX_PULSE_US);
    localparam logic [9:0]  SPAN        = 10'(MAX_PULSE_US - MIN_PULSE_US);

    typedef enum logic {S_LOW = 1'b0, S_HIGH = 1'b1} state_t;

    // len = MIN + (v * (MAX - MIN)) >> 8, with 255 pinned to exactly MAX.
    function automatic logic [11:0] map_len(input logic [7:0] v);
        if (v == 8'hFF) return MAX_LEN;
        return MIN_LEN + 12'((18'(v) * 18'(SPAN)) >> 8);
    endfunction

    // cnt_q is the frame position of the cycle that the next edge opens;
    // all outputs are registered from it, so the pin tracks the counter
    // with no extra cycle of latency.
    logic [14:0] cnt_q, cnt_d;
    logic [7:0]  pend_q, pend_d;
    logic [11:0] len_q, len_d;
    state_t      state_q, state_d;
    logic        pwm_q, pwm_d;
    logic        frame_start_q, frame_start_d;
    logic        boundary;
    logic        trip;
    logic [7:0]  cmd;

    assign boundary = (cnt_q == '0);

`ifdef PWM_FAILSAFE_EN
    localparam int unsigned      FS_W     = $clog2(FAILSAFE_FRAMES + 1);
    localparam logic [FS_W-1:0]  FS_LIMIT = FS_W'(FAILSAFE_FRAMES);

    logic [FS_W-1:0] fs_cnt_q, fs_cnt_d;
    logic            failsafe_q, failsafe_d;

    // A strobe always wins: it clears the watchdog and the failsafe flag,
    // and a strobe coinciding with a boundary is never treated as a timeout.
    always_comb begin
        fs_cnt_d   = fs_cnt_q;
        failsafe_d = failsafe_q;
        trip       = boundary && !value_valid && (fs_cnt_q == FS_LIMIT);
        if (value_valid) begin
            fs_cnt_d   = '0;
            failsafe_d = 1'b0;
        end else if (boundary) begin
            if (fs_cnt_q == FS_LIMIT) failsafe_d = 1'b1;
            else                      fs_cnt_d   = fs_cnt_q + FS_W'(1);
        end
    end

    assign failsafe = failsafe_q;
`else
    assign trip     = 1'b0;
    assign failsafe = 1'b0;
`endif

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned, which would infer a latch.
        cmd    = value_valid ? value_in : pend_q;  // same-edge strobe bypasses
        pend_d = cmd;
        cnt_d  = (cnt_q == PERIOD_LAST) ? '0 : cnt_q + 15'd1;

        len_d = len_q;
        if (boundary) len_d = (arm && !trip) ? map_len(cmd) : MIN_LEN;

        state_d = state_q;
        if (boundary)                 state_d = S_HIGH;
        else if (cnt_q == 15'(len_q)) state_d = S_LOW;

        pwm_d         = (state_d == S_HIGH);
        frame_start_d = boundary;
    end

    always_ff @(posedge us_clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (!resetn) begin
            cnt_q         <= '0;
            pend_q        <= '0;
            len_q         <= MIN_LEN;
            state_q       <= S_LOW;
            pwm_q         <= 1'b0;
            frame_start_q <= 1'b0;
`ifdef PWM_FAILSAFE_EN
            fs_cnt_q      <= '0;
            failsafe_q    <= 1'b0;
`endif
        end else begin
            cnt_q         <= cnt_d;
            pend_q        <= pend_d;
            len_q         <= len_d;
            state_q       <= state_d;
            pwm_q         <= pwm_d;
            frame_start_q <= frame_start_d;
`ifdef PWM_FAILSAFE_EN
            fs_cnt_q      <= fs_cnt_d;
            failsafe_q    <= failsafe_d;
`endif
        end
    end

    assign pwm_out      = pwm_q;
    assign frame_start  = frame_start_q;
    assign pulse_len_us = len_q;

endmodule

// File: tb/tb_pwm_transmitter.sv
// -----------------------------------------------------------------------------
// tb_pwm_transmitter
//
// Directed bench for pwm_transmitter with a shortened 4000-cycle frame and a
// 2-frame watchdog; pulse limits stay at 1000/2000 so the mapped lengths are
// the familiar ones. Each frame is walked cycle by cycle: the high run is
// measured, frame_start spacing and pulse_len_us stability are checked, and
// strobes/arm changes are injected at chosen frame positions. A strobe driven
// at position PERIOD-1 is sampled by the edge that opens the next frame.
// -----------------------------------------------------------------------------
module tb_pwm_transmitter;

    localparam int PERIOD    = 4000;
    localparam int FS_FRAMES = 2;
`ifdef PWM_FAILSAFE_EN
    localparam int FS_ON = 1;
`else
    localparam int FS_ON = 0;
`endif

    typedef enum int {EV_NONE, EV_STROBE, EV_ARM} ev_kind_e;

    typedef struct {
        logic [7:0] val;      // strobed mid-frame
        logic       arm_v;    // arm level set mid-frame
        int         exp_len;  // expected length of the following frame
    } vec_t;

    logic        us_clk = 1'b0;
    logic        resetn;
    logic [7:0]  value_in;
    logic        value_valid;
    logic        arm;
    logic        pwm_out;
    logic        frame_start;
    logic [11:0] pulse_len_us;
    logic        failsafe;

    int n_vec = 0;
    int n_bad = 0;

    pwm_transmitter #(
        .PERIOD_US      (PERIOD),
        .MIN_PULSE_US   (1000),
        .MAX_PULSE_US   (2000),
        .FAILSAFE_FRAMES(FS_FRAMES)
    ) dut (
        .us_clk      (us_clk),
        .resetn      (resetn),
        .value_in    (value_in),
        .value_valid (value_valid),
        .arm         (arm),
        .pwm_out     (pwm_out),
        .frame_start (frame_start),
        .pulse_len_us(pulse_len_us),
        .failsafe    (failsafe)
    );

    always #5 us_clk = ~us_clk;

    task automatic step();
        @(posedge us_clk);
        #1;
    endtask

    task automatic check(input string name, input int actual, input int expected);
        n_vec++;
        if (actual != expected) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic apply_event(input ev_kind_e k, input int p, input logic [7:0] v, input int pos);
        if (pos == p) begin
            case (k)
                EV_STROBE: begin value_in = v; value_valid = 1'b1; end
                EV_ARM:    arm = v[0];
                default:   ;
            endcase
        end
    endtask

    // Called at position 0 of a frame; returns at position 0 of the next.
    task automatic check_frame(input string name, input int exp_len, input int exp_fs,
                               input ev_kind_e k1, input int p1, input logic [7:0] v1,
                               input ev_kind_e k2, input int p2, input logic [7:0] v2,
                               output int fs_after1);
        int high_lead, high_total, extra_starts, len0, len_end, start0, fs0, framing_ok;
        bit leading;
        high_lead = 0; high_total = 0; extra_starts = 0; len_end = -1;
        leading = 1'b1; fs_after1 = -1;
        start0 = int'(frame_start);
        len0   = int'(pulse_len_us);
        fs0    = int'(failsafe);
        for (int pos = 0; pos < PERIOD; pos++) begin
            if (pwm_out === 1'b1) begin
                high_total++;
                if (leading) high_lead++;
            end else begin
                leading = 1'b0;
            end
            if (pos > 0 && frame_start !== 1'b0) extra_starts++;
            if (pos == p1 + 1) fs_after1 = int'(failsafe);
            if (pos == PERIOD - 1) len_end = int'(pulse_len_us);
            value_valid = 1'b0;
            apply_event(k1, p1, v1, pos);
            apply_event(k2, p2, v2, pos);
            step();
        end
        value_valid = 1'b0;
        framing_ok = (start0 == 1 && extra_starts == 0 && frame_start === 1'b1) ? 1 : 0;
        check($sformatf("%s.len_at_start", name), len0, exp_len);
        check($sformatf("%s.len_at_end", name), len_end, exp_len);
        check($sformatf("%s.high_run", name), high_lead, exp_len);
        check($sformatf("%s.high_total", name), high_total, exp_len);
        check($sformatf("%s.framing", name), framing_ok, 1);
        check($sformatf("%s.failsafe", name), fs0, exp_fs);
    endtask

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation still running, got timeout, expected completion");
        $fatal(1, "tb_pwm_transmitter: timeout");
    end

    initial begin
        vec_t vecs[7];
        int   prev_exp;
        int   fs_after;

        vecs[0] = '{val: 8'd128, arm_v: 1'b1, exp_len: 1500};
        vecs[1] = '{val: 8'd0,   arm_v: 1'b1, exp_len: 1000};
        vecs[2] = '{val: 8'd1,   arm_v: 1'b1, exp_len: 1003};
        vecs[3] = '{val: 8'd254, arm_v: 1'b1, exp_len: 1992};
        vecs[4] = '{val: 8'd255, arm_v: 1'b1, exp_len: 2000};
        vecs[5] = '{val: 8'd255, arm_v: 1'b0, exp_len: 1000};  // disarm mid-pulse
        vecs[6] = '{val: 8'd255, arm_v: 1'b1, exp_len: 2000};  // re-arm

        resetn = 1'b0; value_in = 8'd0; value_valid = 1'b0; arm = 1'b1;
        repeat (3) step();
        check("reset.pwm_out", int'(pwm_out), 0);
        check("reset.frame_start", int'(frame_start), 0);
        check("reset.pulse_len", int'(pulse_len_us), 1000);
        check("reset.failsafe", int'(failsafe), 0);

        // Release: the first cycle after is a boundary with pending = 0.
        resetn = 1'b1;
        step();
        check_frame("first_frame", 1000, 0, EV_NONE, -10, 8'd0, EV_NONE, -10, 8'd0, fs_after);

        // Strobe and arm change while the current pulse is high; the current
        // frame must keep its length, the next one takes the new command.
        prev_exp = 1000;
        for (int i = 0; i < 7; i++) begin
            check_frame($sformatf("vec%0d", i), prev_exp, 0,
                        EV_STROBE, 500, vecs[i].val, EV_ARM, 600, {7'd0, vecs[i].arm_v},
                        fs_after);
            prev_exp = vecs[i].exp_len;
        end

        // Strobe 200 sampled by the edge that opens the next frame: bypasses.
        check_frame("pre_bypass", prev_exp, 0, EV_STROBE, PERIOD - 1, 8'd200,
                    EV_NONE, -10, 8'd0, fs_after);
        // Two strobes in one frame: the later one (90) wins.
        check_frame("bypass", 1781, 0, EV_STROBE, 2200, 8'd50, EV_STROBE, 3000, 8'd90, fs_after);

        // Reset mid-pulse at position 700 of the 1351 frame.
        check("two_strobe.len", int'(pulse_len_us), 1351);
        repeat (700) step();
        check("pre_reset.pwm_out", int'(pwm_out), 1);
        resetn = 1'b0;
        step();
        check("mid_reset.pwm_out", int'(pwm_out), 0);
        check("mid_reset.frame_start", int'(frame_start), 0);
        check("mid_reset.pulse_len", int'(pulse_len_us), 1000);
        resetn = 1'b1;
        step();
        // Pending was cleared by reset, so this frame is MIN, not 1351.
        check_frame("after_reset", 1000, 0, EV_STROBE, 500, 8'd255, EV_NONE, -10, 8'd0, fs_after);

        // Watchdog: FS_FRAMES full-length frames, then failsafe (if built in).
        for (int i = 0; i < FS_FRAMES; i++)
            check_frame($sformatf("hold%0d", i), 2000, 0, EV_NONE, -10, 8'd0,
                        EV_NONE, -10, 8'd0, fs_after);
        check_frame("timeout", (FS_ON != 0) ? 1000 : 2000, FS_ON,
                    EV_STROBE, 2500, 8'd255, EV_NONE, -10, 8'd0, fs_after);
        check("timeout.failsafe_after_strobe", fs_after, 0);
        check_frame("recovered", 2000, 0, EV_NONE, -10, 8'd0, EV_NONE, -10, 8'd0, fs_after);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
